// File: rtl/lvds_tx_framer.sv
// Transmit framer: buffers user words in a small FIFO and hands one word to the
// serializer per synchronized request edge, with training after reset and idle fill.
module lvds_tx_framer #(
    parameter int                          PARALLEL_WIDTH = 8,
    parameter int                          FIFO_DEPTH     = 4,
    parameter int                          TRAIN_WORDS    = 16,
    parameter logic [PARALLEL_WIDTH-1:0]   IDLE_WORD      = 8'hBC
) (
    input  logic                            clk_sys,
    input  logic                            reset,
    input  logic [PARALLEL_WIDTH-1:0]       tx_data_in,
    input  logic                            tx_data_valid,
    output logic                            tx_data_ready,
    input  logic                            ser_word_req,
    output logic [PARALLEL_WIDTH-1:0]       serialized_word,
    output logic                            tx_frame_pulse,
    output logic                            tx_word_is_data,
    output logic                            tx_training,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int TCW = $clog2(TRAIN_WORDS + 1);

    typedef enum logic {ST_TRAIN, ST_DATA} state_t;

    state_t                     state_q, state_d;
    logic [TCW-1:0]             train_cnt_q, train_cnt_d;
    logic                       sync1_q, sync2_q, sync3_q;
    logic                       req_edge;
    logic [PARALLEL_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]              level_q, level_d;
    logic [PARALLEL_WIDTH-1:0]  word_q, word_d;
    logic                       is_data_q, is_data_d;
    logic                       pulse_q;
    logic                       push, pop;

    // Request arrives from another domain; sync3 is only the edge-detect history.
    assign req_edge = sync2_q & ~sync3_q;

    assign tx_data_ready   = !reset && (level_q != LW'(FIFO_DEPTH));
    assign push            = tx_data_valid && tx_data_ready;
    assign serialized_word = word_q;
    assign tx_frame_pulse  = pulse_q;
    assign tx_word_is_data = is_data_q;
    assign tx_training     = (state_q == ST_TRAIN);
    assign fifo_level      = level_q;

    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        word_d      = word_q;
        is_data_d   = is_data_q;
        pop         = 1'b0;
        if (req_edge) begin
            if (state_q == ST_TRAIN) begin
                word_d      = IDLE_WORD;
                is_data_d   = 1'b0;
                train_cnt_d = train_cnt_q - TCW'(1);
                if (train_cnt_q == TCW'(1)) begin
                    state_d = ST_DATA;
                end
            end else if (level_q != '0) begin
                pop       = 1'b1;
                word_d    = mem[rd_ptr_q];
                is_data_d = 1'b1;
            end else begin
                word_d    = IDLE_WORD;
                is_data_d = 1'b0;
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_TRAIN;
            train_cnt_q <= TCW'(TRAIN_WORDS);
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            word_q      <= '0;
            is_data_q   <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            train_cnt_q <= train_cnt_d;
            sync1_q     <= ser_word_req;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            word_q      <= word_d;
            is_data_q   <= is_data_d;
            pulse_q     <= req_edge;
        end
    end

    // Storage has no reset so it maps onto distributed/block RAM.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data_in;
        end
    end
endmodule

// File: tb/tb_lvds_tx_framer.sv
// Directed bench for lvds_tx_framer: training, data, full FIFO, latency, reset.
module tb_lvds_tx_framer;
    logic       clk_sys = 1'b0;
    logic       reset;
    logic [7:0] tx_data_in;
    logic       tx_data_valid;
    logic       tx_data_ready;
    logic       ser_word_req;
    logic [7:0] serialized_word;
    logic       tx_frame_pulse;
    logic       tx_word_is_data;
    logic       tx_training;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;

    lvds_tx_framer #(
        .PARALLEL_WIDTH (8),
        .FIFO_DEPTH     (4),
        .TRAIN_WORDS    (16),
        .IDLE_WORD      (8'hBC)
    ) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .tx_data_in      (tx_data_in),
        .tx_data_valid   (tx_data_valid),
        .tx_data_ready   (tx_data_ready),
        .ser_word_req    (ser_word_req),
        .serialized_word (serialized_word),
        .tx_frame_pulse  (tx_frame_pulse),
        .tx_word_is_data (tx_word_is_data),
        .tx_training     (tx_training),
        .fifo_level      (fifo_level)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s observed %0h expected %0h", tag, obs, exp);
    endtask

    // One request: rise before edge k, word/pulse at k+2, pulse gone at k+3.
    task automatic do_req(input string tag, input logic [7:0] w, input logic d,
                          input logic tr, input logic [2:0] lvl);
        @(negedge clk_sys); ser_word_req = 1'b1;
        @(posedge clk_sys);
        @(posedge clk_sys); #1;
        chk({tag, "_early_pulse"}, 32'(tx_frame_pulse), 32'd0);
        @(posedge clk_sys); #1;
        chk({tag, "_pulse"}, 32'(tx_frame_pulse), 32'd1);
        chk({tag, "_word"}, 32'(serialized_word), 32'(w));
        chk({tag, "_is_data"}, 32'(tx_word_is_data), 32'(d));
        chk({tag, "_training"}, 32'(tx_training), 32'(tr));
        chk({tag, "_level"}, 32'(fifo_level), 32'(lvl));
        @(negedge clk_sys); ser_word_req = 1'b0;
        @(posedge clk_sys); #1;
        chk({tag, "_pulse_width"}, 32'(tx_frame_pulse), 32'd0);
        @(posedge clk_sys);
    endtask

    task automatic push(input logic [7:0] w, input logic [2:0] lvl);
        @(negedge clk_sys); tx_data_valid = 1'b1; tx_data_in = w;
        @(posedge clk_sys); #1;
        chk("push_level", 32'(fifo_level), 32'(lvl));
        @(negedge clk_sys); tx_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_sys); reset = 1'b1;
        @(posedge clk_sys); #1;
        chk("ready_in_reset", 32'(tx_data_ready), 32'd0);
        @(posedge clk_sys);
        @(negedge clk_sys); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tx_data_in = '0; tx_data_valid = 1'b0; ser_word_req = 1'b0;
        do_reset();
        @(posedge clk_sys); #1;
        chk("rst_word", 32'(serialized_word), 32'd0);
        chk("rst_pulse", 32'(tx_frame_pulse), 32'd0);
        chk("rst_is_data", 32'(tx_word_is_data), 32'd0);
        chk("rst_training", 32'(tx_training), 32'd1);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ready", 32'(tx_data_ready), 32'd1);

        // Training: 16 idle words, training drops with the 16th
        for (int i = 0; i < 16; i++) begin
            do_req($sformatf("train%0d", i), 8'hBC, 1'b0, (i < 15), 3'd0);
        end
        do_req("post_train_idle", 8'hBC, 1'b0, 1'b0, 3'd0);

        // Data in order, then idle once drained
        push(8'h11, 3'd1);
        push(8'h22, 3'd2);
        push(8'h33, 3'd3);
        do_req("data11", 8'h11, 1'b1, 1'b0, 3'd2);
        do_req("data22", 8'h22, 1'b1, 1'b0, 3'd1);
        do_req("data33", 8'h33, 1'b1, 1'b0, 3'd0);
        do_req("drained_idle", 8'hBC, 1'b0, 1'b0, 3'd0);

        // Fill to full, fifth word waits for a pop, pointers wrap
        push(8'hA0, 3'd1);
        push(8'hA1, 3'd2);
        push(8'hA2, 3'd3);
        push(8'hA3, 3'd4);
        @(negedge clk_sys); tx_data_valid = 1'b1; tx_data_in = 8'hA4;
        @(posedge clk_sys); @(posedge clk_sys); #1;
        chk("full_ready", 32'(tx_data_ready), 32'd0);
        chk("full_level", 32'(fifo_level), 32'd4);
        do_req("full_popA0", 8'hA0, 1'b1, 1'b0, 3'd3);
        chk("refill_level", 32'(fifo_level), 32'd4);
        tx_data_valid = 1'b0;
        do_req("wrapA1", 8'hA1, 1'b1, 1'b0, 3'd3);
        do_req("wrapA2", 8'hA2, 1'b1, 1'b0, 3'd2);
        do_req("wrapA3", 8'hA3, 1'b1, 1'b0, 3'd1);
        do_req("wrapA4", 8'hA4, 1'b1, 1'b0, 3'd0);

        // Push into empty FIFO on the same edge as a request: idle goes out first
        @(negedge clk_sys); ser_word_req = 1'b1;
        @(posedge clk_sys);
        @(posedge clk_sys);
        @(negedge clk_sys); tx_data_valid = 1'b1; tx_data_in = 8'hA5;
        @(posedge clk_sys); #1;
        chk("same_cycle_pulse", 32'(tx_frame_pulse), 32'd1);
        chk("same_cycle_word", 32'(serialized_word), 32'hBC);
        chk("same_cycle_is_data", 32'(tx_word_is_data), 32'd0);
        chk("same_cycle_level", 32'(fifo_level), 32'd1);
        @(negedge clk_sys); tx_data_valid = 1'b0; ser_word_req = 1'b0;
        @(posedge clk_sys); @(posedge clk_sys);
        do_req("after_same_A5", 8'hA5, 1'b1, 1'b0, 3'd0);

        // Reset with buffered words: contents discarded, training restarts
        push(8'hC1, 3'd1);
        push(8'hC2, 3'd2);
        push(8'hC3, 3'd3);
        do_reset();
        @(posedge clk_sys); #1;
        chk("rst2_level", 32'(fifo_level), 32'd0);
        chk("rst2_training", 32'(tx_training), 32'd1);
        chk("rst2_word", 32'(serialized_word), 32'd0);
        for (int i = 0; i < 16; i++) begin
            do_req($sformatf("retrain%0d", i), 8'hBC, 1'b0, (i < 15), 3'd0);
        end
        do_req("rst2_empty_idle", 8'hBC, 1'b0, 1'b0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
